// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared DMEM geometry, owner-state encoding and hold-counter
//                helper for the two-requester DMEM arbiter.
//  Contents    : DMEM_ADDR_W / DMEM_DATA_W   DMEM geometry (32 x 16)
//                owner_e                     arbiter ownership state
//                hold_inc()                  saturating hold-count increment
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam int DMEM_ADDR_W = 5;
  localparam int DMEM_DATA_W = 16;

  // Hold counter is 4 bits wide and saturates rather than wrapping, so a
  // long single-requester stream can never alias back below MAX_HOLD.
  localparam int                HOLD_W   = 4;
  localparam logic [HOLD_W-1:0] HOLD_SAT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_e;

  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] cnt);
    return (cnt == HOLD_SAT) ? cnt : cnt + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the two requester ports and the DMEM port seen by
//                the arbiter.
//  Modports    : slave  - the arbiter (takes requests, drives acks, read
//                         data and the DMEM address/data/write-enable)
//                master - the environment (requesters and the DMEM itself)
//  Signals     : reqN_i/weN_i/addrN_i/wdataN_i  requester N access
//                ackN_o                          requester N granted (comb)
//                rvalidN_o/rdataN_o              registered read return
//                mem_addr_o/mem_wdata_o/mem_we_o to DMEM
//                mem_rdata_i                     from DMEM (comb read)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);

  logic              req0_i;
  logic              we0_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [DATA_W-1:0] wdata0_i;
  logic              ack0_o;
  logic              rvalid0_o;
  logic [DATA_W-1:0] rdata0_o;

  logic              req1_i;
  logic              we1_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata1_i;
  logic              ack1_o;
  logic              rvalid1_o;
  logic [DATA_W-1:0] rdata1_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    input  mem_rdata_i,
    output ack0_o, rvalid0_o, rdata0_o,
    output ack1_o, rvalid1_o, rdata1_o,
    output mem_addr_o, mem_wdata_o, mem_we_o
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, addr1_i, wdata1_i,
    output mem_rdata_i,
    input  ack0_o, rvalid0_o, rdata0_o,
    input  ack1_o, rvalid1_o, rdata1_o,
    input  mem_addr_o, mem_wdata_o, mem_we_o
  );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_rdport.sv
// ============================================================================
//  Module      : dmem_arb_rdport
//  Description : Per-requester read-return register. Captures DMEM read data
//                on the edge that ends a read grant and raises a one-cycle
//                valid strobe; the data holds until the next read grant.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_capture       read grant to this requester this cycle
//                i_rdata         DMEM combinational read data
//                o_rvalid        one-cycle read-valid pulse
//                o_rdata         captured read data
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_rdport
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_capture,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_capture;
      if (i_capture) begin
        r_rdata <= i_rdata;
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-port 32x16 DMEM between requester 0 (CPU
//                load/store) and requester 1 (loader/DMA). One requester is
//                granted per cycle, combinationally from the request levels
//                and the ownership state. Round-robin with a bounded hold:
//                while both request, the current owner keeps the memory for
//                at most MAX_HOLD consecutive grants.
//  Ports       : clk, rst_n       clock, async active-low reset
//                bus (slave)      requester ports + DMEM port
//                conflict_cnt_o   cycles with both requests (saturating),
//                                 present only with DMEM_ARB_STATS_EN
//  Parameters  : ADDR_W, DATA_W   DMEM geometry
//                MAX_HOLD         1..15, consecutive-grant limit under
//                                 contention
//  Options     : `define DMEM_ARB_STATS_EN adds the conflict counter port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   conflict_cnt_o
`endif
);

  localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);

  owner_e            r_owner;
  owner_e            w_owner_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_last;        // last requester served (1 => 0 wins a tie)
  logic              w_last_nxt;

  logic              w_both;
  logic              w_gnt0;
  logic              w_gnt1;

  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_mem_we;

  assign w_both = bus.req0_i & bus.req1_i;

  // --------------------------------------------------------------------------
  // Ownership state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= IDLE;
      r_hold_cnt <= '0;
      r_last     <= 1'b1;
    end else begin
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_last     <= w_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant decision and next-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_nxt = IDLE;
    w_hold_nxt  = '0;
    w_last_nxt  = r_last;

    if (w_both) begin
      // The current owner keeps the memory only while under its hold limit;
      // after that (or from IDLE) the one not served last takes over.
      if (r_owner == OWN0 && r_hold_cnt < c_max_hold) begin
        w_gnt0 = 1'b1;
      end else if (r_owner == OWN1 && r_hold_cnt < c_max_hold) begin
        w_gnt1 = 1'b1;
      end else if (r_last) begin
        w_gnt0 = 1'b1;
      end else begin
        w_gnt1 = 1'b1;
      end
    end else if (bus.req0_i) begin
      w_gnt0 = 1'b1;
    end else if (bus.req1_i) begin
      w_gnt1 = 1'b1;
    end

    if (w_gnt0) begin
      w_owner_nxt = OWN0;
      w_hold_nxt  = (r_owner == OWN0) ? hold_inc(r_hold_cnt) : 4'd1;
      w_last_nxt  = 1'b0;
    end else if (w_gnt1) begin
      w_owner_nxt = OWN1;
      w_hold_nxt  = (r_owner == OWN1) ? hold_inc(r_hold_cnt) : 4'd1;
      w_last_nxt  = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // DMEM drive: granted requester's address/data, zeros when idle
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    if (w_gnt0) begin
      w_mem_addr  = bus.addr0_i;
      w_mem_wdata = bus.wdata0_i;
      w_mem_we    = bus.we0_i;
    end else if (w_gnt1) begin
      w_mem_addr  = bus.addr1_i;
      w_mem_wdata = bus.wdata1_i;
      w_mem_we    = bus.we1_i;
    end
  end

  // Acks and the write strobe are combinational from the request inputs, so
  // they must be masked explicitly while reset is asserted; this also makes
  // a reset mid-access abort the write before the DMEM commits it.
  assign bus.ack0_o      = w_gnt0 & rst_n;
  assign bus.ack1_o      = w_gnt1 & rst_n;
  assign bus.mem_we_o    = w_mem_we & rst_n;
  assign bus.mem_addr_o  = w_mem_addr;
  assign bus.mem_wdata_o = w_mem_wdata;

  // --------------------------------------------------------------------------
  // Read-return registers
  // --------------------------------------------------------------------------
  dmem_arb_rdport #(
    .DATA_W (DATA_W)
  ) u_rdport0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_gnt0 & ~bus.we0_i),
    .i_rdata   (bus.mem_rdata_i),
    .o_rvalid  (bus.rvalid0_o),
    .o_rdata   (bus.rdata0_o)
  );

  dmem_arb_rdport #(
    .DATA_W (DATA_W)
  ) u_rdport1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_capture (w_gnt1 & ~bus.we1_i),
    .i_rdata   (bus.mem_rdata_i),
    .o_rvalid  (bus.rvalid1_o),
    .o_rdata   (bus.rdata1_o)
  );

`ifdef DMEM_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Contention statistics: cycles with both requests raised
  // --------------------------------------------------------------------------
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_both && r_conflict_cnt != 16'hFFFF) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

`default_nettype wire
